// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter sharing one toggle-handshake SDRAM client port.
// The winning request is latched onto mem_* and its ack/read data are returned on completion.
module sdram_port_arbiter #(
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c0_req,
  output logic        c0_ack,
  input  logic [20:0] c0_addr,
  input  logic [15:0] c0_din,
  input  logic [1:0]  c0_be,
  input  logic        c0_we,
  output logic [15:0] c0_dout,
  input  logic        c1_req,
  output logic        c1_ack,
  input  logic [20:0] c1_addr,
  input  logic [15:0] c1_din,
  input  logic [1:0]  c1_be,
  input  logic        c1_we,
  output logic [15:0] c1_dout,
  input  logic        c2_req,
  output logic        c2_ack,
  input  logic [20:0] c2_addr,
  input  logic [15:0] c2_din,
  input  logic [1:0]  c2_be,
  input  logic        c2_we,
  output logic [15:0] c2_dout,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [20:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_be,
  output logic        mem_we,
  input  logic [15:0] mem_dout,
  output logic        busy,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t            state_q, state_d;
  logic [2:0]        ack_q, ack_d;
  logic [2:0][15:0]  dout_q, dout_d;
  logic              mem_req_q, mem_req_d;
  logic [20:0]       mem_addr_q, mem_addr_d;
  logic [15:0]       mem_din_q, mem_din_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic [1:0]        grant_q, grant_d;
  logic              timeout_err_q, timeout_err_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              req_snap_q, req_snap_d;

  logic [2:0]        req_v, pend;
  logic [2:0][20:0]  addr_v;
  logic [2:0][15:0]  din_v;
  logic [2:0][1:0]   be_v;
  logic [2:0]        we_v;
  logic [1:0]        base, win;
  logic [2:0]        cand;
  logic              found;

  assign req_v  = {c2_req, c1_req, c0_req};
  assign addr_v = {c2_addr, c1_addr, c0_addr};
  assign din_v  = {c2_din, c1_din, c0_din};
  assign be_v   = {c2_be, c1_be, c0_be};
  assign we_v   = {c2_we, c1_we, c0_we};
  assign pend   = req_v ^ ack_q;

  // Search starts at rr_ptr in round-robin mode, at client 0 in fixed mode.
  always_comb begin
    base  = (RR_MODE != 0) ? rr_ptr_q : 2'd0;
    win   = 2'd0;
    found = 1'b0;
    cand  = 3'd0;
    for (int i = 0; i < 3; i++) begin
      cand = {1'b0, base} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!found && pend[cand[1:0]]) begin
        found = 1'b1;
        win   = cand[1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ack_d         = ack_q;
    dout_d        = dout_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    mem_be_d      = mem_be_q;
    mem_we_d      = mem_we_q;
    busy_d        = busy_q;
    grant_d       = grant_q;
    timeout_err_d = timeout_err_q;
    rr_ptr_d      = rr_ptr_q;
    wait_cnt_d    = wait_cnt_q;
    req_snap_d    = req_snap_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          mem_addr_d = addr_v[win];
          mem_din_d  = din_v[win];
          mem_be_d   = be_v[win];
          mem_we_d   = we_v[win];
          req_snap_d = req_v[win];
          mem_req_d  = ~mem_req_q;
          grant_d    = win;
          busy_d     = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack == mem_req_q) begin
          if (!mem_we_q) dout_d[grant_q] = mem_dout;
          // Ack with the snapshot so an early re-toggle stays visible as a new request.
          ack_d[grant_q] = req_snap_q;
          rr_ptr_d       = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
          grant_d        = 2'd3;
          busy_d         = 1'b0;
          state_d        = ST_IDLE;
        end else begin
          if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
          if (TIMEOUT_W != 8'd0 && wait_cnt_d == TIMEOUT_W) timeout_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ack_q         <= '0;
      dout_q        <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_be_q      <= '0;
      mem_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      grant_q       <= 2'd3;
      timeout_err_q <= 1'b0;
      rr_ptr_q      <= 2'd0;
      wait_cnt_q    <= 8'd0;
      req_snap_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      dout_q        <= dout_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      mem_be_q      <= mem_be_d;
      mem_we_q      <= mem_we_d;
      busy_q        <= busy_d;
      grant_q       <= grant_d;
      timeout_err_q <= timeout_err_d;
      rr_ptr_q      <= rr_ptr_d;
      wait_cnt_q    <= wait_cnt_d;
      req_snap_q    <= req_snap_d;
    end
  end

  assign c0_ack      = ack_q[0];
  assign c1_ack      = ack_q[1];
  assign c2_ack      = ack_q[2];
  assign c0_dout     = dout_q[0];
  assign c1_dout     = dout_q[1];
  assign c2_dout     = dout_q[2];
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_be      = mem_be_q;
  assign mem_we      = mem_we_q;
  assign busy        = busy_q;
  assign grant       = grant_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares one toggle-handshake SDRAM client port (e.g. the bank-0 ROM/WRAM port of the SDRAM controller) between three requesters: c0 = CPU, c1 = CD/ADPCM DMA, c2 = save-state/loader engine.
- Serialises requests, latches address, data and strobes, forwards them downstream and returns the read data and ack to the granted requester.
- Sits between the core-side masters and the SDRAM controller, in the same clock domain as the controller.

Parameters:
- RR_MODE, 0: 0 = fixed priority (c0 > c1 > c2); 1 = round-robin.
- TIMEOUT, 255: WAIT-state cycles allowed before timeout_err is set. Width 8 bits; 0 disables the check.

Ports:
- clk  in  1  system/SDRAM clock.
- reset  in  1  reset: synchronous, active-high. Clock is clk.
- cN_req  in  1  (N=0..2) toggle request; a request is pending while cN_req != cN_ack.
- cN_ack  out  1  toggle acknowledge.
- cN_addr  in  21  word address [21:1].
- cN_din  in  16  write data.
- cN_be  in  2  byte enables {hi, lo}; 2'b11 for full word.
- cN_we  in  1  1 = write, 0 = read.
- cN_dout  out  16  read data; held until the next read completes for that client.
- mem_req  out  1  toggle request to the SDRAM controller.
- mem_ack  in  1  toggle acknowledge from the SDRAM controller.
- mem_addr  out  21  latched address.
- mem_din  out  16  latched write data.
- mem_be  out  2  latched byte enables.
- mem_we  out  1  latched write flag.
- mem_dout  in  16  read data; valid when mem_ack == mem_req.
- busy  out  1  high in WAIT.
- grant  out  2  index of the client being served; 2'd3 when idle.
- timeout_err  out  1  sticky; set when a WAIT exceeds TIMEOUT.

Behaviour:
- Reset values:
  - cN_ack = 0, cN_dout = 0, mem_req = 0.
  - mem_addr / mem_din / mem_be / mem_we = 0.
  - busy = 0, grant = 3, timeout_err = 0.
  - rr_ptr = 0, state = IDLE, wait counter = 0.
- Pending: pend[N] = cN_req ^ cN_ack, evaluated combinationally.
- IDLE:
  - If any pend bit is set, select the winner:
    - RR_MODE = 0: lowest index wins.
    - RR_MODE = 1: first pending client searching from rr_ptr upward, wrapping 2 → 0.
  - On the same edge:
    - latch addr, din, be and we into mem_*;
    - snapshot req_snap = cW_req;
    - toggle mem_req;
    - set grant = W and busy = 1;
    - clear the wait counter;
    - go to WAIT.
  - If nothing is pending, stay in IDLE.
- WAIT:
  - When mem_ack == mem_req (registered compare of the live input):
    - if mem_we = 0, cW_dout <= mem_dout; writes leave cW_dout unchanged;
    - cW_ack <= req_snap;
    - rr_ptr <= (W == 2) ? 0 : W + 1;
    - grant = 3, busy = 0, state = IDLE.
  - Otherwise increment the wait counter, saturating at 255. When the counter reaches TIMEOUT and TIMEOUT != 0, set timeout_err. No abort; WAIT continues until mem_ack arrives.
- Latency:
  - Client toggle at edge 0 → mem_req toggles at edge 1.
  - Controller acks at edge k → cN_ack toggles at edge k+1.
  - Next grant at edge k+2 at the earliest, because IDLE takes one cycle.
- Requests arriving during WAIT stay pending; they are arbitrated in the next IDLE.
- A client that toggles cN_req again before its ack is a protocol violation. The arbiter acks with the snapshot value, so the second toggle appears as a new pending request.
- A simultaneous request from all clients in fixed mode is served c0, c1, c2 only if c0 does not re-request. Fixed mode gives no starvation guarantee.
- mem_* outputs hold their values between requests; the controller samples them only on a mem_req toggle.
- Reset mid-operation: all state is forced to reset values, the outstanding transfer is dropped and no ack is given. Reset must be applied together with the controller reset, so mem_ack is 0 afterwards.

Test Plan:
- Single read: c0 read, addr 0x01234, controller returns 0xBEEF two cycles after the mem_req toggle → mem_addr = 0x01234, c0_dout = 0xBEEF, c0_ack toggles exactly one cycle after mem_ack, grant back to 3.
- Write latch: c1 write, din 0x55AA, be 2'b01 → mem_we = 1, mem_din = 0x55AA, mem_be = 01; c1_dout unchanged; c1_ack toggles.
- Fixed priority, RR_MODE = 0: c0, c1 and c2 toggle in the same cycle, c0 re-toggles immediately after each ack → c0 granted repeatedly, c1 and c2 stay pending.
- Round-robin, RR_MODE = 1: all three clients pending continuously → grant sequence 0, 1, 2, 0, 1, 2; each ack in order; one idle cycle between grants.
- Timeout: TIMEOUT = 4, controller withholds mem_ack for 10 cycles → timeout_err rises on the 4th WAIT cycle and stays set; the transfer then completes normally on the late ack.
- Mid-transfer reset: reset asserted in WAIT → next cycle all acks 0, mem_req 0, grant 3, timeout_err 0; a new c2 request afterwards completes normally.
